ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of the single-cycle core: owns the fetch PC, issues
//  word reads to instruction memory, buffers returned words in a small FIFO, presents {inst, pc}
//  to decode with valid/ready. Supports redirect (jump/branch) with squash of in-flight responses.
// PARAMETERS
//  RESET_PC   32'h8000_0000  fetch address after reset
//  FIFO_DEPTH 2              instruction buffer entries (power of 2, >=2); also max in-flight credit
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; no backpressure, in request order, >=1 cycle after accept
//  imem_rsp_data   in   32  instruction word
//  inst_valid      out  1   buffered instruction available to decode
//  inst_ready      in   1   decode consumes the head entry
//  inst            out  32  instruction word
//  inst_pc         out  32  address of inst
//  redirect_valid  in   1   one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   32  new fetch PC (bits [1:0] ignored, forced 0)
//  halt            out  1   fetch stopped on zero instruction (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, in_flight=0, drop_cnt=0; imem_req_valid=0 in reset,
//    inst_valid=0, halt=0. First request may assert the cycle after rst_n deasserts.
//  - Request: imem_req_valid = !halt && (in_flight + fifo_count < FIFO_DEPTH) && !redirect_valid.
//    imem_req_addr = fetch_pc. On accept: fetch_pc += 4 (wraps mod 2^32), in_flight++.
//    Once asserted, valid/addr held stable until accepted (unless redirect).
//  - Response: in_flight--. If drop_cnt>0: discard word, drop_cnt--. Else push {data, pc};
//    push pc tracked by a separate rsp_pc register advanced +4 per kept push.
//    Credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
//  - Output: inst/inst_pc = FIFO head; inst_valid = !empty. Pop on inst_valid && inst_ready.
//    Same-cycle push+pop on a full FIFO is legal (count unchanged). Latency from request accept
//    with 1-cycle memory: inst_valid the cycle after imem_rsp_valid (registered FIFO).
//  - Redirect (priority over everything): next cycle fetch_pc=rsp_pc=redirect_pc, FIFO flushed,
//    drop_cnt = in_flight (after that cycle's response/accept accounting), halt cleared.
//    A response arriving in the redirect cycle is discarded. inst_valid=0 the cycle after.
//    Simultaneous pop+redirect: pop takes effect, then flush.
//  - in_flight/drop_cnt width: $clog2(FIFO_DEPTH)+1 bits; never exceed FIFO_DEPTH.
//  - Reset mid-operation: all state cleared asynchronously; memory must also drop pending reads.
// CONFIGURATION
//  IFU_ZERO_HALT_EN defined: a kept response with data==32'h0 is still pushed, then halt=1,
//    no further requests; outstanding responses after it are discarded; cleared only by
//    redirect or reset. Bench finish condition keys off halt.
//  Not defined: zero words are ordinary instructions; halt tied to 0.
// STRUCTURE
//  Package npc_pkg: XLEN=32, inst_t (logic [31:0]), NOP=32'h0000_0013, default RESET_PC.
//  Sub-module ifu_fifo: synchronous FIFO, WIDTH=64, DEPTH=FIFO_DEPTH, push/pop/flush, full/empty/
//  count; async active-low reset. ifu_fetch holds PC, credit, drop and halt logic only.
// TESTING
//  1. Reset, imem always ready, 1-cycle rsp of addr-as-data, inst_ready=1 -> inst_pc sequence
//     8000_0000, _0004, _0008... one per cycle after 2-cycle startup.
//  2. inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests accepted, then req_valid=0;
//     release -> in-order drain, no loss/duplication.
//  3. 3-cycle memory latency, 2 in flight, redirect_valid to 8000_0100 -> both stale responses
//     dropped, first delivered inst_pc=8000_0100.
//  4. imem_req_ready=0 for 5 cycles -> req_valid and addr stable throughout; accept advances PC.
//  5. IFU_ZERO_HALT_EN, word 0 at 8000_000C -> delivered with pc 8000_000C, halt=1, no more
//     requests; redirect to 8000_0000 -> halt=0, fetch resumes.
//  6. rst_n pulsed low mid-stream with 2 in flight -> outputs at reset values immediately,
//     refetch from RESET_PC.

Source files
------------

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared types and constants for the fetch stage
package npc_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] inst_t;

  localparam inst_t           NOP          = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    inst_t           inst;
    logic [XLEN-1:0] pc;
  } fetch_ent_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction memory and decode handshakes of the fetch stage
interface ifu_fetch_if;
  import npc_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  inst_t           imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  inst_t           inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - registered instruction buffer with push/pop/flush
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_pop_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC, request credit, squash and halt control; IFU_ZERO_HALT_EN stops fetch on a zero word
module ifu_fetch import npc_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ifu_fetch_if.master      bus,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             halt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            r_run;
  logic            r_halt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_in_flight;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_in_flight_nxt;
  logic [CW:0]     w_credit_used;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_keep;
  logic            w_pop;
  logic            w_halt_set;
  fetch_ent_t      w_push_ent;
  fetch_ent_t      w_head;

  // Buffered plus outstanding words may never exceed the buffer size, so a response always has room.
  assign w_credit_used   = {1'b0, r_in_flight} + {1'b0, w_fifo_count};
  assign w_req_valid     = r_run && !r_halt && (w_credit_used < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
  assign w_accept        = w_req_valid && bus.imem_req_ready;
  assign w_keep          = bus.imem_rsp_valid && (r_drop_cnt == '0) && !r_halt && !redirect_valid;
  assign w_pop           = !w_fifo_empty && bus.inst_ready;
  assign w_in_flight_nxt = r_in_flight + CW'(w_accept) - CW'(bus.imem_rsp_valid);
  assign w_push_ent      = '{inst: bus.imem_rsp_data, pc: r_rsp_pc};

`ifdef IFU_ZERO_HALT_EN
  assign w_halt_set = w_keep && (bus.imem_rsp_data == '0);
`else
  assign w_halt_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_halt      <= 1'b0;
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_in_flight <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_run       <= 1'b1;
      r_in_flight <= w_in_flight_nxt;
      if (redirect_valid) begin
        // Everything still outstanding belongs to the old path and is squashed on return.
        r_fetch_pc <= word_align(redirect_pc);
        r_rsp_pc   <= word_align(redirect_pc);
        r_drop_cnt <= w_in_flight_nxt;
        r_halt     <= 1'b0;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_keep)   r_rsp_pc   <= r_rsp_pc + 32'd4;
        if (bus.imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_halt_set) r_halt <= 1'b1;
      end
    end
  end

  ifu_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_keep),
    .i_push_data (w_push_ent),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_keep && w_fifo_full && !w_pop));

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = !w_fifo_empty;
  assign bus.inst           = w_fifo_empty ? NOP : w_head.inst;
  assign bus.inst_pc        = w_head.pc;
  assign halt               = r_halt;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized fetch-stage bench against an epoch-tagged memory and delivery scoreboard
module tb_ifu_fetch;
  import npc_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RPC     = 32'h8000_0000;
  localparam logic [31:0] NO_ZERO = 32'hFFFF_FFFF;
`ifdef IFU_ZERO_HALT_EN
  localparam bit ZH = 1'b1;
`else
  localparam bit ZH = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        halt;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  pend_t       pend[$];
  logic [63:0] mq[$];
  int cyc = 0, epoch = 0, last_due = 0, lat = 1;
  int rdy_pct = 100, irdy_pct = 100, redir_pct = 0;
  int accepts = 0, rel = 0, first_iv = -1, s0 = 0, a0 = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_req = RPC, zero_addr = NO_ZERO, force_pc = '0, first_pop_pc = '0;
  bit halted = 0, warm = 0, force_redir = 0, want_first = 0, saw_zero = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == zero_addr) ? 32'h0 : a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    epoch++;
    exp_req  = RPC;
    halted   = 0;
    warm     = 0;
    last_due = cyc;
  endtask

  task automatic drive();
    cyc++;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.inst_ready     = ($urandom_range(99) < irdy_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 0;
    end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = {16'h8000, 16'($urandom)};
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
  endtask

  task automatic observe();
    pend_t       p;
    logic        exp_rv;
    logic [31:0] w;
    if (!rst_n) begin
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_inst_valid", bus.inst_valid, 0);
      chk("rst_halt", halt, 0);
      model_reset();
      return;
    end
    exp_rv = warm && !halted && (pend.size() + mq.size() < DEPTH) && !redirect_valid;
    chk("req_valid", bus.imem_req_valid, exp_rv);
    chk("inst_valid", bus.inst_valid, mq.size() != 0);
    chk("halt", halt, halted);
    if (bus.inst_valid && first_iv < 0) first_iv = cyc;
    if (bus.inst_valid && bus.inst_ready && mq.size() > 0) begin
      chk("inst_pc", bus.inst_pc, mq[0][31:0]);
      chk("inst", bus.inst, mq[0][63:32]);
      if (want_first) begin
        first_pop_pc = bus.inst_pc;
        want_first   = 0;
      end
      if (bus.inst_pc == zero_addr && bus.inst == 32'h0) saw_zero = 1;
      void'(mq.pop_front());
    end
    if (bus.imem_rsp_valid) begin
      p = pend.pop_front();
      if (p.epoch == epoch && !halted) begin
        w = memword(p.addr);
        mq.push_back({w, p.addr});
        if (ZH && w == 32'h0) begin
          halted = 1;
          epoch++;
        end
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_req);
      accepts++;
      p.addr   = exp_req;
      p.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      p.epoch  = epoch;
      last_due = p.due;
      pend.push_back(p);
      exp_req += 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      mq.delete();
      exp_req = {redirect_pc[31:2], 2'b00};
      halted  = 0;
    end
    warm = 1;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_rst();
    rel        = cyc + 1;
    first_iv   = -1;
    want_first = 1;
    rst_n      = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1;
    force_pc    = pc;
    step();
    want_first  = 1;
  endtask

  task automatic wait_inflight(input string tag);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (pend.size() == 2) got = 1;
      else step();
    end
    chk(tag, got, 1);
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    @(posedge clk);
    #1;

    steps(3);
    release_rst();
    steps(20);
    chk("t1_startup", first_iv - rel, 3);
    chk("t1_first_pc", first_pop_pc, RPC);

    irdy_pct = 0;
    s0 = pend.size() + mq.size();
    a0 = accepts;
    steps(10);
    chk("t2_accepts", accepts - a0 + s0, DEPTH);
    chk("t2_req_valid", bus.imem_req_valid, 0);
    chk("t2_inst_valid", bus.inst_valid, 1);
    irdy_pct = 100;
    steps(12);

    lat = 3;
    wait_inflight("t3_two_inflight");
    redirect_to(32'h8000_0100);
    chk("t3_flush", bus.inst_valid, 0);
    steps(15);
    chk("t3_first_pc", first_pop_pc, 32'h8000_0100);

    lat = 1;
    steps(6);
    rdy_pct = 0;
    steps(2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", bus.imem_req_valid, 1);
      chk("t4_hold_addr", bus.imem_req_addr, exp_req);
    end
    rdy_pct = 100;
    a0 = accepts;
    step();
    chk("t4_accepted", accepts - a0, 1);
    chk("t4_pc_advance", bus.imem_req_addr, exp_req);

    steps(4);
    zero_addr = 32'h8000_000C;
    saw_zero  = 0;
`ifdef IFU_ZERO_HALT_EN
    redirect_to(RPC);
    for (int i = 0; i < 40 && !halt; i++) step();
    chk("t5_halt_set", halt, 1);
    steps(6);
    chk("t5_zero_delivered", saw_zero, 1);
    a0 = accepts;
    steps(6);
    chk("t5_no_requests", accepts - a0, 0);
    chk("t5_req_valid_low", bus.imem_req_valid, 0);
    zero_addr = NO_ZERO;
    redirect_to(RPC);
    chk("t5_halt_clear", halt, 0);
    steps(8);
    chk("t5_resume", accepts > a0, 1);
    chk("t5_resume_pc", first_pop_pc, RPC);
`else
    redirect_to(RPC);
    steps(20);
    chk("t5_zero_delivered", saw_zero, 1);
    chk("t5_no_halt", halt, 0);
    zero_addr = NO_ZERO;
`endif

    lat = 3;
    wait_inflight("t6_two_inflight");
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", bus.imem_req_valid, 0);
    chk("t6_inst_valid", bus.inst_valid, 0);
    chk("t6_halt", halt, 0);
    model_reset();
    steps(2);
    lat = 1;
    release_rst();
    steps(12);
    chk("t6_first_pc", first_pop_pc, RPC);
    chk("t6_startup", first_iv - rel, 3);

    redir_pct = 3;
    rdy_pct   = 70;
    irdy_pct  = 60;
    for (int k = 0; k < 8; k++) begin
      lat = $urandom_range(1, 3);
      steps(50);
    end
    redir_pct = 0;
    rdy_pct   = 100;
    irdy_pct  = 100;
    lat       = 1;
    steps(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
